// File: rtl/iter_muldiv_unit.sv
//-----------------------------------------------------------------------------
// iter_muldiv_unit
//
// Multi-cycle multiply/divide execution unit for the LEGv8 datapath. Operands
// arrive from the register file buses. One iteration runs per clock: a
// shift-add step for MUL/UMULH or a restoring-divide step for UDIV/SDIV.
// Every operation takes exactly WIDTH cycles. The write-back value, the
// destination tag and the write strobe then drive BusW/RW/RegWr.
//
// Ports:
//   Clk      - system clock, all state changes on posedge
//   Reset    - asynchronous active-high reset
//   Start    - request, sampled only in IDLE or FINISH
//   Op       - 00 MUL, 01 UMULH, 10 UDIV, 11 SDIV
//   OpA      - multiplicand / dividend (BusA)
//   OpB      - multiplier / divisor (BusB)
//   RdIn     - destination register tag
//   Busy     - high while an operation is iterating
//   Done     - one-cycle completion pulse
//   Result   - completed result, held until the next completion
//   RdOut    - tag of the completed operation
//   RegWrOut - register-file write strobe (same as Done)
//-----------------------------------------------------------------------------
module iter_muldiv_unit #(
  parameter int WIDTH = 64,
  parameter int CW    = 7
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic [4:0]       RdIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       RdOut,
  output logic             RegWrOut
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [1:0]    OpMul   = 2'b00;
  localparam logic [1:0]    OpUmulh = 2'b01;
  localparam logic [1:0]    OpUdiv  = 2'b10;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] accHi_q;
  logic [WIDTH-1:0] accLo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             negate_q;
  logic             divZero_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic [4:0]       rdOut_q;

  logic [WIDTH-1:0] loadHi_d, loadLo_d, loadOpnd_d;
  logic             loadNeg_d, loadDz_d;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulSum, remSh, divDiff;
  logic [WIDTH-1:0] accHi_d, accLo_d, final_d;

  // The operands are prepared at accept. For a multiply, the multiplier sits
  // in the low accumulator so its LSB can be examined each step. For a
  // divide, the dividend sits in the low accumulator and shifts out MSB
  // first. SDIV works on magnitudes, and the sign is fixed up at the end.
  always_comb begin
    absA       = (Op == 2'b11 && OpA[WIDTH-1]) ? -OpA : OpA;
    absB       = (Op == 2'b11 && OpB[WIDTH-1]) ? -OpB : OpB;
    loadHi_d   = '0;
    loadLo_d   = OpB;
    loadOpnd_d = OpA;
    loadNeg_d  = 1'b0;
    loadDz_d   = 1'b0;
    if (Op[1]) begin
      loadLo_d   = absA;
      loadOpnd_d = absB;
      loadNeg_d  = (Op == 2'b11) && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
      loadDz_d   = (OpB == '0);
    end
  end

  // One iteration step. Multiply adds the multiplicand under the current
  // multiplier bit, then shifts the double-width product right. Divide
  // shifts the next dividend bit into the partial remainder and keeps the
  // difference only when it does not go negative.
  always_comb begin
    mulSum  = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opnd_q} : '0);
    remSh   = {accHi_q, accLo_q[WIDTH-1]};
    divDiff = remSh - {1'b0, opnd_q};
    accHi_d = mulSum[WIDTH:1];
    accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
    if (op_q[1]) begin
      accHi_d = divDiff[WIDTH] ? remSh[WIDTH-1:0] : divDiff[WIDTH-1:0];
      accLo_d = {accLo_q[WIDTH-2:0], ~divDiff[WIDTH]};
    end
    case (op_q)
      OpMul:   final_d = accLo_d;
      OpUmulh: final_d = accHi_d;
      OpUdiv:  final_d = divZero_q ? '0 : accLo_d;
      default: final_d = divZero_q ? '0 : (negate_q ? -accLo_d : accLo_d);
    endcase
  end

  // Control FSM and datapath registers. The last iteration lands on the
  // WIDTH-th edge after accept. The result is captured from the step values
  // of that same edge, so the latency is exactly WIDTH cycles.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      opnd_q    <= '0;
      negate_q  <= 1'b0;
      divZero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      rdOut_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        RUN: begin
          accHi_q <= accHi_d;
          accLo_q <= accLo_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LastCnt) begin
            state_q  <= FINISH;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= final_d;
            rdOut_q  <= rd_q;
          end
        end
        default: begin
          if (Start) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            op_q      <= Op;
            rd_q      <= RdIn;
            accHi_q   <= loadHi_d;
            accLo_q   <= loadLo_d;
            opnd_q    <= loadOpnd_d;
            negate_q  <= loadNeg_d;
            divZero_q <= loadDz_d;
            busy_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign RegWrOut = done_q;
  assign Result   = result_q;
  assign RdOut    = rdOut_q;

endmodule
